// File: rtl/count_decoder_mon_if.sv
// Interface for the count decoder monitor: counter-side strobe, mode and count in,
// decoded value and sequence-tracking status out.
interface count_decoder_mon_if #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned ERR_W = 8
) ();
  logic             en;
  logic             mode;
  logic [WIDTH-1:0] count_in;
  logic [WIDTH-1:0] bin_out;
  logic             bin_valid;
  logic             locked;
  logic             seq_err;
  logic [ERR_W-1:0] err_count;

  // Driver side: the counter (or a bench) feeding the monitor.
  modport master (
    output en, mode, count_in,
    input  bin_out, bin_valid, locked, seq_err, err_count
  );

  // Monitor side.
  modport slave (
    input  en, mode, count_in,
    output bin_out, bin_valid, locked, seq_err, err_count
  );
endinterface

// File: rtl/count_decoder_mon.sv
// Decodes a binary/Gray counter stream back to binary and checks that successive samples
// form a +1 sequence, reporting lock, sequence-error pulses and a saturating error count.
module count_decoder_mon #(
  parameter int unsigned WIDTH      = 3,
  parameter int unsigned LOCK_COUNT = 2,
  parameter int unsigned ERR_W      = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  count_decoder_mon_if.slave mon
);

  typedef enum logic [1:0] {StUnlocked, StAcq, StLocked} state_e;

  localparam logic [3:0]       LockTarget = 4'(LOCK_COUNT);
  localparam logic [ERR_W-1:0] ErrMax     = {ERR_W{1'b1}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [3:0]       match_cnt_q, match_cnt_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] bin_out_q, bin_out_d;
  logic             bin_valid_q, bin_valid_d;
  logic             locked_q, locked_d;
  logic             seq_err_q, seq_err_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  logic [WIDTH-1:0] dec;
  logic [WIDTH-1:0] prev_inc;
  logic             inc_ok;
  logic             acc;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    dec = mon.count_in;
    acc = 1'b0;
    if (mon.mode) begin
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        acc    = acc ^ mon.count_in[i];
        dec[i] = acc;
      end
    end
  end

  assign prev_inc = prev_q + WIDTH'(1);
  assign inc_ok   = (dec == prev_inc);

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    match_cnt_d = match_cnt_q;
    mode_d      = mode_q;
    bin_out_d   = bin_out_q;
    bin_valid_d = 1'b0;
    locked_d    = locked_q;
    seq_err_d   = 1'b0;
    err_count_d = err_count_q;

    if (mon.en) begin
      bin_out_d   = dec;
      bin_valid_d = 1'b1;
      mode_d      = mon.mode;
      prev_d      = dec;

      if (state_q == StUnlocked) begin
        match_cnt_d = 4'd0;
        state_d     = StAcq;
      end else if (mon.mode != mode_q) begin
        // Encoding changed: resynchronise without flagging an error.
        locked_d    = 1'b0;
        match_cnt_d = 4'd0;
        state_d     = StAcq;
      end else begin
        unique case (state_q)
          StAcq: begin
            if (inc_ok) begin
              match_cnt_d = match_cnt_q + 4'd1;
              if (match_cnt_q + 4'd1 == LockTarget) begin
                locked_d = 1'b1;
                state_d  = StLocked;
              end
            end else begin
              match_cnt_d = 4'd0;
            end
          end
          StLocked: begin
            if (!inc_ok) begin
              seq_err_d   = 1'b1;
              locked_d    = 1'b0;
              match_cnt_d = 4'd0;
              state_d     = StAcq;
              if (err_count_q != ErrMax) begin
                err_count_d = err_count_q + ERR_W'(1);
              end
            end
          end
          default: begin
            state_d = StAcq;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StUnlocked;
      prev_q      <= '0;
      match_cnt_q <= 4'd0;
      mode_q      <= 1'b0;
      bin_out_q   <= '0;
      bin_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      seq_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      match_cnt_q <= match_cnt_d;
      mode_q      <= mode_d;
      bin_out_q   <= bin_out_d;
      bin_valid_q <= bin_valid_d;
      locked_q    <= locked_d;
      seq_err_q   <= seq_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign mon.bin_out   = bin_out_q;
  assign mon.bin_valid = bin_valid_q;
  assign mon.locked    = locked_q;
  assign mon.seq_err   = seq_err_q;
  assign mon.err_count = err_count_q;

endmodule

// File: doc/count_decoder_mon.md
Name: count_decoder_mon

Overview:
- Receiving end of the 3-bit binary/Gray counter interface. Takes the counter's mode and count outputs and decodes them back to plain binary.
- Checks that consecutive samples form a valid +1 sequence, including wrap. Reports lock status, sequence-error pulses and a saturating error count.
- Sits beside any counter instance as a bench or on-chip monitor.

Parameters:
- WIDTH, 3, width of count_in and bin_out.
- LOCK_COUNT, 2, consecutive correct increments required to assert locked (range 1..15).
- ERR_W, 8, width of err_count.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  sample strobe; count_in and mode are examined only on edges where en=1.
- mode  input  1  encoding of count_in: 0 = binary, 1 = Gray.
- count_in  input  WIDTH  count value from the counter.
- bin_out  output  WIDTH  registered decoded binary value.
- bin_valid  output  1  high for one cycle after each sample.
- locked  output  1  sequence tracking established.
- seq_err  output  1  one-cycle pulse on a sequence break while locked.
- err_count  output  ERR_W  saturating count of seq_err pulses.

Behaviour:
- reset=0 (async):
  - bin_out=0, bin_valid=0, locked=0, seq_err=0, err_count=0.
  - Internal prev=0, match_cnt=0, mode_q=0, state=UNLOCKED.
  - Reset takes effect immediately, mid-sequence included. The first edge after release behaves as an ordinary edge.
- Decode (combinational, internal):
  - mode=0: dec = count_in.
  - mode=1: dec[WIDTH-1] = count_in[WIDTH-1]; dec[i] = dec[i+1] ^ count_in[i], for i from WIDTH-2 down to 0.
- Output timing:
  - All outputs are registered and update on the same edge that samples the inputs (1-cycle latency from input to output).
  - en=1 edge: bin_out<=dec, bin_valid<=1, mode_q<=mode, prev<=dec.
  - en=0 edge: bin_valid<=0, seq_err<=0; all other registers hold.
- Increment check:
  - ok = (dec == prev+1 mod 2^WIDTH), so 7->0 is valid for WIDTH=3.
  - A repeated value (dec == prev) is NOT ok.
- FSM, evaluated on en=1 edges only:
  - UNLOCKED: capture dec, match_cnt<=0, go to ACQ. No error.
  - ACQ, mode==mode_q, ok:
    - match_cnt<=match_cnt+1.
    - If match_cnt+1==LOCK_COUNT: go to LOCKED, locked<=1.
  - ACQ, mode==mode_q, not ok: match_cnt<=0, stay in ACQ. No error.
  - LOCKED, mode==mode_q, ok: stay in LOCKED.
  - LOCKED, mode==mode_q, not ok:
    - seq_err<=1 for one cycle.
    - err_count<=err_count+1, saturating at 2^ERR_W-1.
    - locked<=0, match_cnt<=0, go to ACQ.
  - Any state, mode!=mode_q (mode switch):
    - Resynchronise: locked<=0, match_cnt<=0, go to ACQ.
    - No seq_err and no err_count change. prev<=dec.
- Simultaneous events: a mode switch takes priority over the increment check on the same edge.
- seq_err is cleared on every edge where it is not being set.
- err_count is cleared only by reset.

Test Plan:
1. Reset and hold: reset=0 for 2 cycles, then en=1, mode=0, count_in 0,1,2,3 on successive edges.
   - All outputs 0 during reset.
   - bin_out follows 0,1,2,3 one edge late.
   - locked=1 after the edge sampling 2.
   - seq_err never asserts.
2. Gray decode and wrap: mode=1, count_in 000,001,011,010,110,111,101,100,000,001.
   - bin_out = 0,1,2,3,4,5,6,7,0,1.
   - locked stays 1 through the 7->0 wrap.
   - err_count=0.
3. Sequence break: locked in binary, then count_in 4,5,0 (counter reset mid-run).
   - seq_err pulses 1 cycle on the edge sampling 0.
   - locked=0 and err_count=1.
   - Relocks after 1,2 (LOCK_COUNT=2).
4. Mode switch: locked binary at 3, then mode=1 with count_in 110.
   - No seq_err; locked drops to 0; bin_out=4.
   - Gray 111,101 then gives locked=1 with err_count unchanged.
5. Strobe gaps and stall: en toggles 1,0,1,0 with count_in 2,9(ignored),3.
   - bin_valid = 1,0,1,0 and lock is unaffected.
   - While locked, en=1 with a repeated 3: seq_err=1, err_count+1.
6. Saturation and async reset: ERR_W=2, force 5 breaks.
   - err_count stops at 3.
   - Assert reset between clock edges: all outputs go to 0 immediately, with no clock edge needed.
